// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width level windows separated by a low gap.
// Optional macro PULSE_STRETCH_ACK_EN adds an ack port that holds the window open until acked.
module pulse_stretcher #(
   parameter int unsigned HIGH_CYCLES = 4,
   parameter int unsigned LOW_CYCLES  = 2,
   parameter int unsigned QUEUE_DEPTH = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       pulse_in,
   input  logic       clear_overflow,
`ifdef PULSE_STRETCH_ACK_EN
   input  logic       ack,
`endif
   output logic       level_out,
   output logic       busy,
   output logic [3:0] pending_count,
   output logic       overflow
);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   localparam logic [7:0] HighLast = 8'(HIGH_CYCLES - 1);
   localparam logic [7:0] LowLast  = 8'(LOW_CYCLES - 1);
   localparam logic [3:0] QDepth   = 4'(QUEUE_DEPTH);

   state_e     r_state, w_state_d;
   logic [7:0] r_cnt, w_cnt_d, w_cnt_inc;
   logic [3:0] r_pend, w_pend_d;
   logic       r_level, r_busy, r_ovf, w_ovf_d;
   logic       w_high_done, w_go_high, w_deq, w_enq, w_drop;

`ifdef PULSE_STRETCH_ACK_EN
   logic r_ack_seen, w_ack_seen_d;

   // The ack may arrive in the exit cycle itself, so the live input counts too.
   assign w_high_done = (r_cnt >= HighLast) && (r_ack_seen || ack);

   always_comb begin
      w_ack_seen_d = r_ack_seen;
      if (w_state_d == StHigh && r_state != StHigh) begin
         w_ack_seen_d = 1'b0;
      end else if (r_state == StHigh && ack) begin
         w_ack_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_ack_seen <= 1'b0;
      end else begin
         r_ack_seen <= w_ack_seen_d;
      end
   end
`else
   assign w_high_done = (r_cnt >= HighLast);
`endif

   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = w_cnt_inc;
      w_go_high = 1'b0;
      w_deq     = 1'b0;
      w_enq     = pulse_in;
      unique case (r_state)
         StIdle: begin
            w_cnt_d = 8'd0;
            if (pulse_in || r_pend != 4'd0) w_go_high = 1'b1;
         end
         StHigh: begin
            if (w_high_done) begin
               w_state_d = StLow;
               w_cnt_d   = 8'd0;
            end
         end
         StLow: begin
            if (r_cnt >= LowLast) begin
               w_cnt_d = 8'd0;
               if (pulse_in || r_pend != 4'd0) w_go_high = 1'b1;
               else                              w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
      // Queued events are served first; a live pulse is consumed directly only if the queue is empty.
      if (w_go_high) begin
         w_state_d = StHigh;
         w_cnt_d   = 8'd0;
         w_deq     = (r_pend != 4'd0);
         w_enq     = pulse_in && w_deq;
      end
   end

   always_comb begin
      w_drop   = w_enq && !w_deq && (r_pend == QDepth);
      w_pend_d = r_pend;
      if (w_enq && !w_deq && !w_drop) w_pend_d = r_pend + 4'd1;
      else if (w_deq && !w_enq)       w_pend_d = r_pend - 4'd1;
      w_ovf_d = r_ovf;
      if (w_drop)              w_ovf_d = 1'b1;
      else if (clear_overflow) w_ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= StIdle;
         r_cnt   <= 8'd0;
         r_pend  <= 4'd0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_pend  <= w_pend_d;
         r_level <= (w_state_d == StHigh);
         r_busy  <= (w_state_d != StIdle) || (w_pend_d != 4'd0);
         r_ovf   <= w_ovf_d;
      end
   end

   assign level_out     = r_level;
   assign busy          = r_busy;
   assign pending_count = r_pend;
   assign overflow      = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed self-checking bench for pulse_stretcher at default parameters (H=4, L=2, D=3).
// Cycle i drives inputs after edge i; sample slot i holds outputs just after edge i+1.
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       pulse_in = 1'b0;
   logic       clear_overflow = 1'b0;
   logic       ack = 1'b1;
   logic       level_out, busy, overflow;
   logic [3:0] pending_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] lv, bz, ov;
   logic [3:0]  pc [64];

   localparam logic [63:0] AckAll = '1;

   always #5 clk = ~clk;

   pulse_stretcher dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .pulse_in       (pulse_in),
      .clear_overflow (clear_overflow),
`ifdef PULSE_STRETCH_ACK_EN
      .ack            (ack),
`endif
      .level_out      (level_out),
      .busy           (busy),
      .pending_count  (pending_count),
      .overflow       (overflow)
   );

   task automatic do_reset();
      pulse_in       = 1'b0;
      clear_overflow = 1'b0;
      ack            = 1'b1;
      n_rst          = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input logic [63:0] p, input logic [63:0] c, input logic [63:0] a,
                          input int n);
      lv = '0;
      bz = '0;
      ov = '0;
      for (int i = 0; i < 64; i++) pc[i] = 4'd0;
      for (int i = 0; i < n; i++) begin
         pulse_in       = p[i];
         clear_overflow = c[i];
         ack            = a[i];
         @(posedge clk);
         #1;
         lv[i] = level_out;
         bz[i] = busy;
         ov[i] = overflow;
         pc[i] = pending_count;
      end
      pulse_in       = 1'b0;
      clear_overflow = 1'b0;
      ack            = 1'b1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      #3;
      n_tests++;
      if (level_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_level got %b want 0", level_out);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %b want 0", busy);
      end
      n_tests++;
      if (pending_count !== 4'd0) begin
         n_fail++; $display("FAIL reset_pending got %0d want 0", pending_count);
      end
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_overflow got %b want 0", overflow);
      end
   endtask

   task automatic test_single();
      do_reset();
      run_seq(64'h1, 64'h0, AckAll, 12);
      n_tests++;
      if (lv !== 64'hF) begin
         n_fail++; $display("FAIL single_level got %h want %h", lv, 64'hF);
      end
      n_tests++;
      if (bz !== 64'h3F) begin
         n_fail++; $display("FAIL single_busy got %h want %h", bz, 64'h3F);
      end
      n_tests++;
      if (ov !== 64'h0) begin
         n_fail++; $display("FAIL single_overflow got %h want 0", ov);
      end
   endtask

   task automatic test_queue();
      do_reset();
      run_seq(64'hF, 64'h0, AckAll, 28);
      n_tests++;
      if (lv !== 64'h3C_F3CF) begin
         n_fail++; $display("FAIL queue_level got %h want %h", lv, 64'h3CF3CF);
      end
      n_tests++;
      if (bz !== 64'hFF_FFFF) begin
         n_fail++; $display("FAIL queue_busy got %h want %h", bz, 64'hFFFFFF);
      end
      n_tests++;
      if (pc[3] !== 4'd3) begin
         n_fail++; $display("FAIL queue_peak got %0d want 3", pc[3]);
      end
      n_tests++;
      if (pc[6] !== 4'd2 || pc[12] !== 4'd1 || pc[18] !== 4'd0) begin
         n_fail++;
         $display("FAIL queue_drain got %0d/%0d/%0d want 2/1/0", pc[6], pc[12], pc[18]);
      end
      n_tests++;
      if (ov !== 64'h0) begin
         n_fail++; $display("FAIL queue_overflow got %h want 0", ov);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      run_seq(64'h1F, 64'h0, AckAll, 30);
      n_tests++;
      if (lv !== 64'h3C_F3CF) begin
         n_fail++; $display("FAIL ovf_level got %h want %h", lv, 64'h3CF3CF);
      end
      n_tests++;
      if (ov !== 64'h3FFF_FFF0) begin
         n_fail++; $display("FAIL ovf_sticky got %h want %h", ov, 64'h3FFFFFF0);
      end
      run_seq(64'h1F, 64'h30, AckAll, 8);
      n_tests++;
      if (ov[4] !== 1'b1) begin
         n_fail++; $display("FAIL ovf_drop_beats_clear got %b want 1", ov[4]);
      end
      n_tests++;
      if (ov[5] !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear got %b want 0", ov[5]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_seq(64'h41, 64'h0, AckAll, 16);
      n_tests++;
      if (lv !== 64'h3CF) begin
         n_fail++; $display("FAIL b2b_level got %h want %h", lv, 64'h3CF);
      end
      n_tests++;
      if (bz !== 64'hFFF) begin
         n_fail++; $display("FAIL b2b_busy got %h want %h", bz, 64'hFFF);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_seq(64'hF, 64'h0, AckAll, 8);
      n_tests++;
      if (pc[7] !== 4'd2 || lv[7] !== 1'b1) begin
         n_fail++; $display("FAIL midrst_setup got pc=%0d lv=%b want pc=2 lv=1", pc[7], lv[7]);
      end
      #2 n_rst = 1'b0;
      #1;
      n_tests++;
      if (level_out !== 1'b0 || busy !== 1'b0 || pending_count !== 4'd0) begin
         n_fail++;
         $display("FAIL midrst_clear got lv=%b busy=%b pc=%0d want 0/0/0",
                  level_out, busy, pending_count);
      end
      #2 n_rst = 1'b1;
      @(posedge clk);
      #1;
      run_seq(64'h0, 64'h0, AckAll, 20);
      n_tests++;
      if (lv !== 64'h0 || bz !== 64'h0) begin
         n_fail++; $display("FAIL midrst_quiet got lv=%h bz=%h want 0/0", lv, bz);
      end
   endtask

`ifdef PULSE_STRETCH_ACK_EN
   task automatic test_ack();
      do_reset();
      run_seq(64'h1, 64'h0, 64'h4, 12);
      n_tests++;
      if (lv !== 64'hF) begin
         n_fail++; $display("FAIL ack_early got %h want %h", lv, 64'hF);
      end
      do_reset();
      run_seq(64'h1, 64'h0, 64'h80, 14);
      n_tests++;
      if (lv !== 64'h7F) begin
         n_fail++; $display("FAIL ack_late got %h want %h", lv, 64'h7F);
      end
      do_reset();
      run_seq(64'h4, 64'h0, 64'h403, 16);
      n_tests++;
      if (lv !== 64'h3FC) begin
         n_fail++; $display("FAIL ack_idle_ignored got %h want %h", lv, 64'h3FC);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_queue();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef PULSE_STRETCH_ACK_EN
      test_ack();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
